// File: rtl/icache_if.sv
// Fetch-side and refill-side bus of the instruction cache.
//   Fetch side : i_req_addr, i_req_ren, i_inval  -> cache
//                o_inst, o_busy                  <- cache
//   Memory side: o_mem_addr, o_mem_ren           <- cache
//                i_mem_ready, i_mem_valid, i_mem_rdata -> cache
// The slave modport is the cache's view; master is the view of the
// surrounding core/memory (or a testbench standing in for both).
interface icache_if;
    logic [31:0] i_req_addr;
    logic        i_req_ren;
    logic        i_inval;
    logic [31:0] o_inst;
    logic        o_busy;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_req_addr, i_req_ren, i_inval, i_mem_ready, i_mem_valid, i_mem_rdata,
        output o_inst, o_busy, o_mem_addr, o_mem_ren
    );

    modport master (
        output i_req_addr, i_req_ren, i_inval, i_mem_ready, i_mem_valid, i_mem_rdata,
        input  o_inst, o_busy, o_mem_addr, o_mem_ren
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Hits return the instruction combinationally in the request cycle; a miss
// raises o_busy and refills one whole line from memory over a ready/valid
// port, then the (still held) request hits.
// Ports:
//   i_clk  : clock, all state updates on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : icache_if.slave (fetch request/response and refill port)
module icache #(
    parameter int NUM_LINES  = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    icache_if.slave  bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int LINE_W = 30 - OFF_W;          // word-aligned line address width
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam int CNT_W  = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LINE_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_reg, state_next;
    logic [NUM_LINES-1:0]  valid_reg, valid_next;
    logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
    logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];
    logic [LINE_W-1:0]     base_reg;             // line being refilled
    logic [CNT_W-1:0]      issue_cnt_reg;
    logic [CNT_W-1:0]      recv_cnt_reg;
    logic                  inval_pend_reg;

    logic [OFF_W-1:0]      req_off;
    logic [IDX_W-1:0]      req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_W-1:0]      fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  busy;
    logic                  mem_ren;
    logic                  start_fill;
    logic                  fill_done;
    logic                  clear_all;
    logic                  unused_addr_bits;

    assign req_off  = bus.i_req_addr[OFF_W+1:2];
    assign req_idx  = bus.i_req_addr[OFF_W+2 +: IDX_W];
    assign req_tag  = bus.i_req_addr[31 -: TAG_W];
    assign fill_idx = base_reg[IDX_W-1:0];
    assign fill_tag = base_reg[LINE_W-1 -: TAG_W];
    assign unused_addr_bits = ^bus.i_req_addr[1:0];

    assign hit         = bus.i_req_ren & valid_reg[req_idx] & (tag_mem[req_idx] == req_tag);
    assign bus.o_inst  = data_mem[{req_idx, req_off}];
    assign bus.o_busy  = busy;
    assign bus.o_mem_ren  = mem_ren;
    assign bus.o_mem_addr = {base_reg, issue_cnt_reg[OFF_W-1:0], 2'b00};

    // An invalidate in IDLE takes priority over a simultaneous miss; the miss
    // is simply seen again on the following cycle.
    assign start_fill = (state_reg == IDLE) & ~bus.i_inval & bus.i_req_ren & ~hit;
    assign fill_done  = (state_reg == FILL) & bus.i_mem_valid & (recv_cnt_reg == CNT_LAST);
    // An invalidate seen at any point of a fill (including its last cycle)
    // wipes every line, the freshly filled one included, when the fill ends.
    assign clear_all  = ((state_reg == IDLE) & bus.i_inval)
                      | (fill_done & (inval_pend_reg | bus.i_inval));

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        mem_ren    = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = (bus.i_req_ren & ~hit) | bus.i_inval;
                if (start_fill) state_next = FILL;
            end
            FILL: begin
                busy    = 1'b1;
                mem_ren = (issue_cnt_reg < CNT_FULL);
                if (fill_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            base_reg       <= '0;
            issue_cnt_reg  <= '0;
            recv_cnt_reg   <= '0;
            inval_pend_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_fill) begin
                base_reg       <= bus.i_req_addr[31:OFF_W+2];
                issue_cnt_reg  <= '0;
                recv_cnt_reg   <= '0;
                inval_pend_reg <= 1'b0;
            end
            if (state_reg == FILL) begin
                if (mem_ren & bus.i_mem_ready) issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                if (bus.i_mem_valid)           recv_cnt_reg  <= recv_cnt_reg + CNT_W'(1);
                if (fill_done)                 inval_pend_reg <= 1'b0;
                else if (bus.i_inval)          inval_pend_reg <= 1'b1;
            end
        end
    end

    // Per-line valid update: a missing line is dropped as its refill starts
    // so a half-written line can never hit.
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
        assign valid_next[gi] = clear_all                                  ? 1'b0 :
                                (start_fill && req_idx  == IDX_W'(gi))      ? 1'b0 :
                                (fill_done  && fill_idx == IDX_W'(gi))      ? 1'b1 :
                                valid_reg[gi];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) valid_reg <= '0;
        else       valid_reg <= valid_next;
    end

    // Tag and data storage: no reset, contents are qualified by valid_reg.
    always_ff @(posedge i_clk) begin
        if ((state_reg == FILL) && bus.i_mem_valid)
            data_mem[{fill_idx, recv_cnt_reg[OFF_W-1:0]}] <= bus.i_mem_rdata;
        if (fill_done)
            tag_mem[fill_idx] <= fill_tag;
    end
endmodule
